// File: rtl/fft_pkg.sv
// Shared constants, read-side state encoding and the address bit-reversal
// helper for the FFT output reorder buffer.
package fft_pkg;

  localparam int N_FFT = 512;
  localparam int LOG2N = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] addr);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = addr[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. Read data is registered (one-cycle latency).
module fft_reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT output into natural bin order using a ping-pong
// pair of frame banks. Define FFT_REORDER_HALF_SPECTRUM_EN to emit bins 0..N/2 only.
module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int N_FFT = fft_pkg::N_FFT,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx,
  output logic             do_last,
  output logic             busy
);

  import fft_pkg::*;

  localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N_FFT - 1);
`ifdef FFT_REORDER_HALF_SPECTRUM_EN
  localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N_FFT / 2);
`else
  localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N_FFT - 1);
`endif

  // ---------------- write side ----------------
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             frame_done;

  // Combinational so the read side can start on the same edge that stores
  // the final sample; this is what makes bin 0 appear two clocks later.
  assign frame_done = di_en && (wr_cnt_q == WR_LAST);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (di_en) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (frame_done) wr_bank_d = ~wr_bank_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // ---------------- read state machine ----------------
  rd_state_e        state_q;
  logic             rd_bank_q;
  logic [LOG2N-1:0] rd_cnt_q;
  logic             rd_issue;

  assign rd_issue = (state_q == STREAM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_done) begin
            state_q   <= STREAM;
            rd_bank_q <= wr_bank_q;
            rd_cnt_q  <= '0;
          end
        end
        STREAM: begin
          if (rd_cnt_q == RD_LAST) begin
            rd_cnt_q <= '0;
            // A new frame finishing exactly now continues without a bubble.
            if (frame_done) rd_bank_q <= wr_bank_q;
            else            state_q   <= IDLE;
          end else begin
            rd_cnt_q <= rd_cnt_q + LOG2N'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- storage ----------------
  logic [2*WIDTH-1:0] rdata;

  fft_reorder_ram #(
    .DW (2*WIDTH),
    .AW (LOG2N+1)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (di_en),
    .waddr_i ({wr_bank_q, bitrev(wr_cnt_q)}),
    .wdata_i ({di_re, di_im}),
    .re_i    (rd_issue),
    .raddr_i ({rd_bank_q, rd_cnt_q}),
    .rdata_o (rdata)
  );

  // ---------------- output pipeline ----------------
  // vld_pipe_q[0]: RAM data valid, vld_pipe_q[1]: output register valid.
  logic [1:0]       vld_pipe_q;
  logic [LOG2N-1:0] idx1_q;
  logic [WIDTH-1:0] do_re_q, do_im_q;
  logic [LOG2N-1:0] do_idx_q;
  logic             do_last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      idx1_q     <= '0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_idx_q   <= '0;
      do_last_q  <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_issue};
      if (rd_issue) idx1_q <= rd_cnt_q;
      do_last_q  <= vld_pipe_q[0] && (idx1_q == RD_LAST);
      if (vld_pipe_q[0]) begin
        do_re_q  <= rdata[2*WIDTH-1:WIDTH];
        do_im_q  <= rdata[WIDTH-1:0];
        do_idx_q <= idx1_q;
      end
    end
  end

  assign do_en   = vld_pipe_q[1];
  assign do_re   = do_re_q;
  assign do_im   = do_im_q;
  assign do_idx  = do_idx_q;
  assign do_last = do_last_q;
  assign busy    = (state_q == STREAM);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench: random/directed frames against an array model where
// output bin i of a frame equals input position bitrev(i).
module tb_fft_bitrev_reorder;

  localparam int W = 16;
  localparam int N = 512;
  localparam int L = 9;
`ifdef FFT_REORDER_HALF_SPECTRUM_EN
  localparam int NOUT = N/2 + 1;
`else
  localparam int NOUT = N;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0, di_im = '0;
  logic         do_en, do_last, busy;
  logic [W-1:0] do_re, do_im;
  logic [L-1:0] do_idx;

  fft_bitrev_reorder #(.WIDTH(W), .N_FFT(N), .LOG2N(L)) dut (
    .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx),
    .do_last(do_last), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int c; logic [41:0] v; } mon_t;
  mon_t        mon_q[$];
  logic [41:0] exp_q[$];
  int          start_q[$];

  always @(negedge clock)
    if (do_en) mon_q.push_back('{cyc, {do_last, do_idx, do_re, do_im}});

  int n_cmp = 0, n_mis = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < L; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  logic [31:0] fr [N];

  // gap < 0 selects a random gap of 0..3 idle cycles after each sample
  task automatic send(input int n, input int gap);
    int g, cap;
    cap = 0;
    for (int k = 0; k < n; k++) begin
      di_en = 1'b1; di_re = fr[k][31:16]; di_im = fr[k][15:0];
      @(posedge clock); #1;
      di_en = 1'b0;
      if (k == n-1) cap = cyc;
      else begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin @(posedge clock); #1; end
      end
    end
    if (n == N) begin
      chk("busy_on", {63'd0, busy}, 64'd1);
      start_q.push_back(cap + 2);
      for (int i = 0; i < NOUT; i++)
        exp_q.push_back({(i == NOUT-1), L'(i), fr[brev(i)]});
    end
  endtask

  task automatic verify(input int nfr);
    int st, prev, tmo;
    mon_t m;
    for (int f = 0; f < nfr; f++) begin
      st = start_q.pop_front();
      prev = 0;
      for (int i = 0; i < NOUT; i++) begin
        tmo = 0;
        while (mon_q.size() == 0 && tmo < 4*N) begin @(negedge clock); tmo++; end
        if (mon_q.size() == 0) begin
          chk("timeout", 64'(mon_q.size()), 64'd1);
          return;
        end
        m = mon_q.pop_front();
        chk($sformatf("bin%0d", i), 64'(m.v), 64'(exp_q.pop_front()));
        if (i == 0) chk("start_lat", 64'(m.c), 64'(st));
        else        chk("contig", 64'(m.c), 64'(prev + 1));
        prev = m.c;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    repeat (3) @(negedge clock);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_en"}, {63'd0, do_en}, 64'd0);
    chk({tag, "_extra"}, 64'(mon_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) fr[k] = $urandom;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_en",   {63'd0, do_en},   64'd0);
    chk("rst_re",   64'(do_re),       64'd0);
    chk("rst_im",   64'(do_im),       64'd0);
    chk("rst_idx",  64'(do_idx),      64'd0);
    chk("rst_last", {63'd0, do_last}, 64'd0);
    chk("rst_busy", {63'd0, busy},    64'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // impulse at bin 5
    for (int k = 0; k < N; k++) fr[k] = '0;
    fr[brev(5)] = 32'h1234_0ABC;
    send(N, 0); verify(1); chk_idle("imp");

    // ramp: position k carries bitrev(k) / ~bitrev(k)
    for (int k = 0; k < N; k++) fr[k] = {16'(brev(k)), ~16'(brev(k))};
    send(N, 0); verify(1); chk_idle("ramp");

    // back-to-back random frames
    fill_rand(); send(N, 0);
    fill_rand(); send(N, 0);
    verify(2); chk_idle("b2b");

    // gapped input, one sample every 3rd cycle
    fill_rand(); send(N, 2); verify(1); chk_idle("gap");

    // reset while a frame streams out and the next one is partially written
    fill_rand(); send(N, 0);
    fill_rand(); send(300, 0);
`ifndef FFT_REORDER_HALF_SPECTRUM_EN
    chk("pre_rst_en", {63'd0, do_en}, 64'd1);
`endif
    reset_n = 1'b0;
    #1;
    chk("mrst_en",   {63'd0, do_en},   64'd0);
    chk("mrst_re",   64'(do_re),       64'd0);
    chk("mrst_im",   64'(do_im),       64'd0);
    chk("mrst_idx",  64'(do_idx),      64'd0);
    chk("mrst_busy", {63'd0, busy},    64'd0);
    mon_q.delete(); exp_q.delete(); start_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    fill_rand(); send(N, 0); verify(1); chk_idle("post_rst");

    // random-gapped frames, back to back
    fill_rand(); send(N, -1);
    fill_rand(); send(N, -1);
    verify(2); chk_idle("rgap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
